// File: rtl/zoom_pkg.sv
// rtl/zoom_pkg.sv - shared types, constants and mode decode for the zoom copy engine
//
// Purpose: zoom mode encodings, FSM state type, scale-decode helper and the
// coordinate width used for window arithmetic.
// Ports: none (package).

package zoom_pkg;

  typedef enum logic [2:0] {
    ZM_1X      = 3'b000,
    ZM_2X      = 3'b001,
    ZM_4X      = 3'b010,
    ZM_HALF    = 3'b011,
    ZM_QUARTER = 3'b100
  } zoom_mode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_FETCH,
    S_WAIT,
    S_WRITE,
    S_DONE
  } zoom_state_t;

  // Decoded scale: signed power-of-two exponent plus a valid flag.
  typedef struct packed {
    logic              valid;
    logic signed [2:0] shift_exp;
  } zoom_scale_t;

  // Coordinates and window sizes are kept in 16 bits; this covers frame
  // dimensions up to 16383 even after a 4x up-scale of the source.
  localparam int COORD_W = 16;
  typedef logic [COORD_W-1:0] coord_t;

  // Extra accumulator bits: a 4x4 box sum needs four bits above the pixel.
  localparam int ACC_EXT = 4;

  function automatic zoom_scale_t zoom_decode(input logic [2:0] mode);
    zoom_scale_t d;
    d.valid     = 1'b1;
    d.shift_exp = 3'sd0;
    case (mode)
      ZM_1X:      d.shift_exp = 3'sd0;
      ZM_2X:      d.shift_exp = 3'sd1;
      ZM_4X:      d.shift_exp = 3'sd2;
      ZM_HALF:    d.shift_exp = -3'sd1;
      ZM_QUARTER: d.shift_exp = -3'sd2;
      default:    d.valid     = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/zoom_addr_gen.sv
// rtl/zoom_addr_gen.sv - destination raster counters, window test and source address generation
//
// Purpose: walks the destination frame in raster order, reports whether the
// current pixel lies inside the centred image window, and forms the source
// ROM address including the offset inside a down-scale averaging block.
// Ports:
//   i_clk, i_reset_n           clock, async active-low reset
//   i_init                     clear all counters for a new frame
//   i_pix_step                 advance to the next destination pixel
//   i_blk_step                 advance to the next element of the averaging block
//   i_down, i_shamt, i_avg     latched scale: direction, |exponent|, averaging
//   o_dst_addr                 framebuffer address of the current pixel
//   o_src_addr                 ROM address of the current pixel / block element
//   o_in_win                   current pixel is inside the image window
//   o_last_pix                 current pixel is the last one of the frame
//   o_blk_zero                 block offset is at its origin (wrapped after last read)

module zoom_addr_gen
  import zoom_pkg::*;
#(
  parameter int SRC_W = 160,
  parameter int SRC_H = 120,
  parameter int DST_W = 640,
  parameter int DST_H = 480
) (
  input  logic                             i_clk,
  input  logic                             i_reset_n,
  input  logic                             i_init,
  input  logic                             i_pix_step,
  input  logic                             i_blk_step,
  input  logic                             i_down,
  input  logic [1:0]                       i_shamt,
  input  logic                             i_avg,
  output logic [$clog2(DST_W*DST_H)-1:0]   o_dst_addr,
  output logic [$clog2(SRC_W*SRC_H)-1:0]   o_src_addr,
  output logic                             o_in_win,
  output logic                             o_last_pix,
  output logic                             o_blk_zero
);

  localparam int SA_W = $clog2(SRC_W*SRC_H);
  localparam int DA_W = $clog2(DST_W*DST_H);

  localparam coord_t SRC_WC     = coord_t'(SRC_W);
  localparam coord_t SRC_HC     = coord_t'(SRC_H);
  localparam coord_t DST_WC     = coord_t'(DST_W);
  localparam coord_t DST_HC     = coord_t'(DST_H);
  localparam coord_t COORD_ONES = '1;
  localparam logic [SA_W-1:0] SRC_W_A = SA_W'(SRC_W);

  coord_t            r_dx;
  coord_t            r_dy;
  logic [DA_W-1:0]   r_dst_addr;
  logic [SA_W-1:0]   r_row_base;   // sy * SRC_W of the current window row
  logic [SA_W-1:0]   r_blk_off;    // by * SRC_W inside the averaging block
  logic [1:0]        r_bx;
  logic [1:0]        r_by;

  coord_t            w_scl_w, w_scl_h;
  coord_t            w_out_w, w_out_h;
  coord_t            w_off_x, w_off_y;
  coord_t            w_u, w_v, w_sx, w_mask;
  logic              w_in_x, w_in_y;
  logic              w_row_adv;
  logic [SA_W-1:0]   w_row_inc;
  logic [1:0]        w_blk_max;

  always_comb begin
    w_scl_w = i_down ? (SRC_WC >> i_shamt) : (SRC_WC << i_shamt);
    w_scl_h = i_down ? (SRC_HC >> i_shamt) : (SRC_HC << i_shamt);
    w_out_w = (w_scl_w > DST_WC) ? DST_WC : w_scl_w;
    w_out_h = (w_scl_h > DST_HC) ? DST_HC : w_scl_h;
    w_off_x = (DST_WC - w_out_w) >> 1;
    w_off_y = (DST_HC - w_out_h) >> 1;

    w_in_x = (r_dx >= w_off_x) && (r_dx < w_off_x + w_out_w);
    w_in_y = (r_dy >= w_off_y) && (r_dy < w_off_y + w_out_h);

    w_u  = r_dx - w_off_x;
    w_v  = r_dy - w_off_y;
    w_sx = i_down ? (w_u << i_shamt) : (w_u >> i_shamt);

    // Up-scaled rows repeat 2^s times before the source row moves on;
    // down-scaled rows skip 2^|s| source rows every time.
    w_mask    = ~(COORD_ONES << i_shamt);
    w_row_adv = i_down || ((w_v & w_mask) == w_mask);
    w_row_inc = i_down ? (SRC_W_A << i_shamt) : SRC_W_A;

    w_blk_max = 2'd0;
    if (i_avg && i_down) begin
      w_blk_max = (i_shamt == 2'd2) ? 2'd3 : 2'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_dx       <= '0;
      r_dy       <= '0;
      r_dst_addr <= '0;
      r_row_base <= '0;
      r_blk_off  <= '0;
      r_bx       <= '0;
      r_by       <= '0;
    end else if (i_init) begin
      r_dx       <= '0;
      r_dy       <= '0;
      r_dst_addr <= '0;
      r_row_base <= '0;
      r_blk_off  <= '0;
      r_bx       <= '0;
      r_by       <= '0;
    end else begin
      if (i_pix_step) begin
        r_dst_addr <= r_dst_addr + 1'b1;
        if (r_dx == DST_WC - 1'b1) begin
          r_dx <= '0;
          r_dy <= r_dy + 1'b1;
          if (w_in_y && w_row_adv) begin
            r_row_base <= r_row_base + w_row_inc;
          end
        end else begin
          r_dx <= r_dx + 1'b1;
        end
      end
      if (i_blk_step) begin
        if (r_bx == w_blk_max) begin
          r_bx <= '0;
          if (r_by == w_blk_max) begin
            r_by      <= '0;
            r_blk_off <= '0;
          end else begin
            r_by      <= r_by + 2'd1;
            r_blk_off <= r_blk_off + SRC_W_A;
          end
        end else begin
          r_bx <= r_bx + 2'd1;
        end
      end
    end
  end

  assign o_dst_addr = r_dst_addr;
  assign o_src_addr = r_row_base + r_blk_off + SA_W'(w_sx) + SA_W'(r_bx);
  assign o_in_win   = w_in_x && w_in_y;
  assign o_last_pix = (r_dx == DST_WC - 1'b1) && (r_dy == DST_HC - 1'b1);
  assign o_blk_zero = (r_bx == 2'd0) && (r_by == 2'd0);

endmodule

// File: rtl/zoom_copy_engine.sv
// rtl/zoom_copy_engine.sv - power-of-two zoom copier from image ROM into the VGA framebuffer
//
// Purpose: on start, latches the zoom mode and rewrites every framebuffer
// address once, in raster order, with either a scaled source pixel or the
// background colour. Down-scaling can decimate or box-average.
// Ports:
//   i_clk, i_reset_n     clock, async active-low reset
//   i_start              level-sampled frame start (only seen when idle)
//   i_zoom_mode          000=1x 001=2x 010=4x 011=0.5x 100=0.25x, others invalid
//   i_avg_en             box-average (1) or decimate (0) when down-scaling
//   o_rom_addr/i_rom_data  source ROM read port, ROM_LAT cycles latency
//   o_ram_addr/o_ram_data/o_ram_wren  framebuffer write port
//   o_busy               frame in progress
//   o_done               one-cycle end-of-frame pulse
//   o_err                sticky invalid-mode flag, cleared by the next start

module zoom_copy_engine
  import zoom_pkg::*;
#(
  parameter int               SRC_W    = 160,
  parameter int               SRC_H    = 120,
  parameter int               DST_W    = 640,
  parameter int               DST_H    = 480,
  parameter int               PIX_W    = 8,
  parameter int               ROM_LAT  = 1,
  parameter logic [PIX_W-1:0] BG_COLOR = '0
) (
  input  logic                             i_clk,
  input  logic                             i_reset_n,
  input  logic                             i_start,
  input  logic [2:0]                       i_zoom_mode,
  input  logic                             i_avg_en,
  output logic [$clog2(SRC_W*SRC_H)-1:0]   o_rom_addr,
  input  logic [PIX_W-1:0]                 i_rom_data,
  output logic [$clog2(DST_W*DST_H)-1:0]   o_ram_addr,
  output logic [PIX_W-1:0]                 o_ram_data,
  output logic                             o_ram_wren,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_err
);

  localparam int SA_W  = $clog2(SRC_W*SRC_H);
  localparam int DA_W  = $clog2(DST_W*DST_H);
  localparam int ACC_W = PIX_W + ACC_EXT;

  zoom_state_t       r_state, w_next;
  zoom_scale_t       w_dec;

  logic              r_valid, r_down, r_avg;
  logic [1:0]        r_shamt;
  logic [1:0]        r_wait_cnt;
  logic              r_last;
  logic [ACC_W-1:0]  r_acc;

  logic [SA_W-1:0]   r_rom_addr;
  logic [DA_W-1:0]   r_ram_addr;
  logic [PIX_W-1:0]  r_ram_data;
  logic              r_ram_wren, r_busy, r_done, r_err;

  logic              w_init, w_pix_step, w_blk_step, w_wait_last;
  logic [ACC_W-1:0]  w_acc_sum, w_avg_shift;
  logic [PIX_W-1:0]  w_pix_val;

  logic [DA_W-1:0]   w_dst_addr;
  logic [SA_W-1:0]   w_src_addr;
  logic              w_in_win, w_last_pix, w_blk_zero;

  assign w_dec       = zoom_decode(i_zoom_mode);
  assign w_init      = (r_state == S_IDLE) && i_start;
  assign w_blk_step  = (r_state == S_FETCH);
  assign w_pix_step  = (w_next == S_WRITE);
  assign w_wait_last = (r_wait_cnt == 2'(ROM_LAT - 1));

  // The block reads sum into r_acc; the final read is folded in directly so
  // the averaged pixel is ready in the same edge that enters WRITE.
  assign w_acc_sum   = r_acc + {{ACC_EXT{1'b0}}, i_rom_data};
  assign w_avg_shift = w_acc_sum >> {r_shamt, 1'b0};
  assign w_pix_val   = (r_avg && r_down) ? w_avg_shift[PIX_W-1:0] : i_rom_data;

  zoom_addr_gen #(
    .SRC_W (SRC_W),
    .SRC_H (SRC_H),
    .DST_W (DST_W),
    .DST_H (DST_H)
  ) u_addr_gen (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_init     (w_init),
    .i_pix_step (w_pix_step),
    .i_blk_step (w_blk_step),
    .i_down     (r_down),
    .i_shamt    (r_shamt),
    .i_avg      (r_avg),
    .o_dst_addr (w_dst_addr),
    .o_src_addr (w_src_addr),
    .o_in_win   (w_in_win),
    .o_last_pix (w_last_pix),
    .o_blk_zero (w_blk_zero)
  );

  // The address generator advances on the edge entering WRITE, so during
  // WRITE its window flag already describes the following pixel.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_SETUP;
      S_SETUP: begin
        if (!r_valid)      w_next = S_DONE;
        else if (w_in_win) w_next = S_FETCH;
        else               w_next = S_WRITE;
      end
      S_FETCH: w_next = S_WAIT;
      S_WAIT:  begin
        if (w_wait_last) w_next = w_blk_zero ? S_WRITE : S_FETCH;
      end
      S_WRITE: begin
        if (r_last)        w_next = S_DONE;
        else if (w_in_win) w_next = S_FETCH;
        else               w_next = S_WRITE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_valid    <= 1'b0;
      r_down     <= 1'b0;
      r_avg      <= 1'b0;
      r_shamt    <= '0;
      r_wait_cnt <= '0;
      r_last     <= 1'b0;
      r_acc      <= '0;
      r_rom_addr <= '0;
      r_ram_addr <= '0;
      r_ram_data <= '0;
      r_ram_wren <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_busy     <= (w_next != S_IDLE) && (w_next != S_DONE);
      r_done     <= (w_next == S_DONE);
      r_ram_wren <= (w_next == S_WRITE);

      if (w_init) begin
        r_valid <= w_dec.valid;
        r_down  <= w_dec.shift_exp[2];
        r_shamt <= w_dec.shift_exp[2] ? 2'(-w_dec.shift_exp) : 2'(w_dec.shift_exp);
        r_avg   <= i_avg_en;
        r_acc   <= '0;
        r_err   <= 1'b0;
      end else if ((r_state == S_SETUP) && !r_valid) begin
        r_err   <= 1'b1;
      end

      if (r_state == S_FETCH) begin
        r_wait_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 2'd1;
        if (w_wait_last) begin
          r_acc <= w_blk_zero ? '0 : w_acc_sum;
        end
      end

      if (w_next == S_FETCH) begin
        r_rom_addr <= w_src_addr;
      end

      if (w_next == S_WRITE) begin
        r_ram_addr <= w_dst_addr;
        r_last     <= w_last_pix;
        r_ram_data <= (r_state == S_WAIT) ? w_pix_val : BG_COLOR;
      end
    end
  end

  assign o_rom_addr = r_rom_addr;
  assign o_ram_addr = r_ram_addr;
  assign o_ram_data = r_ram_data;
  assign o_ram_wren = r_ram_wren;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;

endmodule

// File: tb/tb_zoom_copy_engine.sv
// tb/tb_zoom_copy_engine.sv - randomized self-checking bench for zoom_copy_engine

module tb_zoom_copy_engine;

  localparam int SRC_W   = 12;
  localparam int SRC_H   = 10;
  localparam int DST_W   = 32;
  localparam int DST_H   = 24;
  localparam int PIX_W   = 8;
  localparam int ROM_LAT = 2;
  localparam logic [7:0] BG = 8'hA5;
  localparam int NSRC = SRC_W * SRC_H;
  localparam int NDST = DST_W * DST_H;
  localparam int SA_W = $clog2(NSRC);
  localparam int DA_W = $clog2(NDST);

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [2:0]        zoom_mode = 3'd0;
  logic              avg_en = 1'b0;
  logic [SA_W-1:0]   rom_addr;
  logic [PIX_W-1:0]  rom_data;
  logic [DA_W-1:0]   ram_addr;
  logic [PIX_W-1:0]  ram_data;
  logic              ram_wren, busy, done, err;

  always #5 clk = ~clk;

  zoom_copy_engine #(
    .SRC_W (SRC_W), .SRC_H (SRC_H), .DST_W (DST_W), .DST_H (DST_H),
    .PIX_W (PIX_W), .ROM_LAT (ROM_LAT), .BG_COLOR (BG)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .i_start     (start),
    .i_zoom_mode (zoom_mode),
    .i_avg_en    (avg_en),
    .o_rom_addr  (rom_addr),
    .i_rom_data  (rom_data),
    .o_ram_addr  (ram_addr),
    .o_ram_data  (ram_data),
    .o_ram_wren  (ram_wren),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err)
  );

  // Source ROM with a ROM_LAT-deep read pipeline.
  logic [7:0] rom   [NSRC];
  logic [7:0] rpipe [ROM_LAT];
  always @(posedge clk) begin
    rpipe[0] <= rom[rom_addr];
    for (int i = 1; i < ROM_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign rom_data = rpipe[ROM_LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wa_q[$];
  int wd_q[$];
  int wt_q[$];
  always @(negedge clk) begin
    if (ram_wren) begin
      wa_q.push_back(int'(ram_addr));
      wd_q.push_back(int'(ram_data));
      wt_q.push_back(cyc);
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int scale_exp(input int mode);
    case (mode)
      0: return 0;
      1: return 1;
      2: return 2;
      3: return -1;
      4: return -2;
      default: return 0;
    endcase
  endfunction

  // Expected content and read count of destination pixel (dy,dx).
  function automatic void model_pix(input int mode, input int avg, input int dy, input int dx,
                                    output int inwin, output int val, output int nreads);
    int s, n, ow, oh, ox, oy, u, v, sum;
    s = scale_exp(mode);
    n = 1;
    if (s >= 0) begin
      ow = SRC_W * (2 ** s);
      oh = SRC_H * (2 ** s);
    end else begin
      n  = 2 ** (-s);
      ow = SRC_W / n;
      oh = SRC_H / n;
    end
    if (ow > DST_W) ow = DST_W;
    if (oh > DST_H) oh = DST_H;
    ox = (DST_W - ow) / 2;
    oy = (DST_H - oh) / 2;
    inwin  = (dx >= ox && dx < ox + ow && dy >= oy && dy < oy + oh) ? 1 : 0;
    val    = int'(BG);
    nreads = 0;
    if (inwin != 0) begin
      u = dx - ox;
      v = dy - oy;
      nreads = 1;
      if (s >= 0) begin
        val = int'(rom[(v / (2 ** s)) * SRC_W + u / (2 ** s)]);
      end else if (avg == 0) begin
        val = int'(rom[(v * n) * SRC_W + u * n]);
      end else begin
        sum = 0;
        for (int by = 0; by < n; by++)
          for (int bx = 0; bx < n; bx++)
            sum += int'(rom[(v * n + by) * SRC_W + u * n + bx]);
        val = sum / (n * n);
        nreads = n * n;
      end
    end
  endfunction

  task automatic run_frame(input int mode, input int avg);
    int t0, tdone, texp, tprev, inw, val, nr, pcyc, nw;
    bit got_done;
    bit valid;
    valid = (mode <= 4);
    wa_q.delete(); wd_q.delete(); wt_q.delete();
    @(negedge clk);
    zoom_mode = 3'(mode);
    avg_en    = avg[0];
    start     = 1'b1;
    t0        = cyc;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("m%0d busy_setup", mode), int'(busy), 1);
    chk($sformatf("m%0d err_cleared", mode), int'(err), 0);
    got_done = 0;
    tdone    = 0;
    for (int c = 0; c < 20000 && !got_done; c++) begin
      if (done) begin
        got_done = 1;
        tdone    = cyc;
      end else begin
        if (busy) begin
          start     = 1'($urandom);
          zoom_mode = 3'($urandom);
          avg_en    = 1'($urandom);
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk($sformatf("m%0d done_seen", mode), int'(got_done), 1);
    chk($sformatf("m%0d busy_at_done", mode), int'(busy), 0);
    chk($sformatf("m%0d err", mode), int'(err), valid ? 0 : 1);
    nw = wa_q.size();
    chk($sformatf("m%0d nwrites", mode), nw, valid ? NDST : 0);
    if (nw > NDST) nw = NDST;
    tprev = t0 + 1;
    texp  = t0 + 1;
    for (int k = 0; k < NDST; k++) begin
      model_pix(mode, avg, k / DST_W, k % DST_W, inw, val, nr);
      pcyc = (inw != 0) ? nr * (1 + ROM_LAT) + 1 : 1;
      texp += pcyc;
      if (k < nw) begin
        chk($sformatf("m%0d a%0d addr", mode, avg), wa_q[k], k);
        chk($sformatf("m%0d a%0d data[%0d]", mode, avg, k), wd_q[k], val);
        chk($sformatf("m%0d a%0d cycles[%0d]", mode, avg, k), wt_q[k] - tprev, pcyc);
        tprev = wt_q[k];
      end
    end
    chk($sformatf("m%0d done_cycle", mode), tdone, valid ? texp + 1 : t0 + 2);
    @(negedge clk);
    chk($sformatf("m%0d done_pulse", mode), int'(done), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, " rom_addr"}, int'(rom_addr), 0);
    chk({tag, " ram_addr"}, int'(ram_addr), 0);
    chk({tag, " ram_data"}, int'(ram_data), 0);
    chk({tag, " ram_wren"}, int'(ram_wren), 0);
    chk({tag, " busy"},     int'(busy), 0);
    chk({tag, " done"},     int'(done), 0);
    chk({tag, " err"},      int'(err), 0);
  endtask

  task automatic reset_mid_frame();
    wa_q.delete(); wd_q.delete(); wt_q.delete();
    @(negedge clk);
    zoom_mode = 3'd0;
    avg_en    = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 5000 && wa_q.size() < 300; c++) @(negedge clk);
    chk("reset_mid reached_300", int'(wa_q.size() >= 300), 1);
    #1 reset_n = 1'b0;
    #1 check_outputs_zero("async_reset");
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("start_in_reset busy", int'(busy), 0);
    start = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic fill_rom();
    for (int i = 0; i < NSRC; i++) rom[i] = 8'($urandom);
  endtask

  initial begin
    fill_rom();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset_n = 1'b1;

    run_frame(0, 0);
    run_frame(1, 0);
    run_frame(2, 1);

    rom[0] = 8'd10; rom[1] = 8'd20; rom[SRC_W] = 8'd30; rom[SRC_W+1] = 8'd41;
    run_frame(3, 1);
    chk("half_avg corner", wd_q[9 * DST_W + 13], 25);
    run_frame(3, 0);
    chk("half_dec corner", wd_q[9 * DST_W + 13], 10);

    fill_rom();
    run_frame(4, 0);
    run_frame(4, 1);
    run_frame(5, 0);
    run_frame(0, 0);
    run_frame(7, 1);
    run_frame(2, 0);

    reset_mid_frame();
    run_frame(1, 1);

    for (int f = 0; f < 4; f++) begin
      fill_rom();
      run_frame(int'($urandom_range(0, 7)), int'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
